// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch controller sitting after the program counter. It reads
//   the current PC, sends instruction-memory reads and drives the PC
//   increment/load controls. Fetched {pc, instr} pairs are buffered in a small
//   FIFO for the decode stage. Jump redirects from execute flush that buffer
//   and reload the PC.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   pc_val                   current PC register value
//   pc_inc/pc_load/pc_in     PC controls (never inc and load together)
//   imem_req/imem_addr       read request toward instruction memory
//   imem_ack/imem_rdata      read completion; may come in the request cycle
//   jmp_valid/jmp_target     single-cycle redirect request
//   ins_valid/ins_data/ins_pc/ins_ready  buffer head toward decode
//   state_dbg                current FSM state (0 = BOOT, 1 = ISSUE)
//
// Handshakes
//   imem: a transfer happens in any cycle with imem_req & imem_ack. While
//   imem_req is high, imem_addr is held until that ack arrives. A jump may
//   drop the request without an ack, so the memory has to accept an
//   abandoned request.
//   decode: the head entry moves in any cycle with ins_valid & ins_ready.
//   ins_valid does not depend on ins_ready.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc_val,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  output logic              state_dbg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {
    BOOT  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] buf_pc   [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];

  logic in_issue;
  logic jump;
  logic has_room;
  logic req;
  logic push;
  logic head_valid;
  logic pop;

  // The request uses the count at the start of the cycle. A pop in the same
  // cycle frees a slot only for the following cycle.
  assign in_issue   = (state == ISSUE);
  assign jump       = in_issue & jmp_valid;
  assign has_room   = (count < CNT_W'(DEPTH));
  assign req        = in_issue & has_room & ~jmp_valid;
  assign push       = req & imem_ack;
  assign head_valid = (count != '0);
  // The flush takes priority over a concurrent pop.
  assign pop        = head_valid & ins_ready & ~jump;

  // Every output is gated with reset_n, so all of them drop to zero as soon
  // as reset asserts, even in the middle of a memory wait.
  assign imem_req  = reset_n & req;
  assign imem_addr = imem_req ? pc_val : '0;
  assign pc_inc    = reset_n & push;
  assign pc_load   = reset_n & ((state == BOOT) | jump);

  always_comb begin
    pc_in = '0;
    if (reset_n) begin
      if (state == BOOT) begin
        pc_in = RESET_VEC;
      end else if (jump) begin
        pc_in = jmp_target;
      end
    end
  end

  assign ins_valid = reset_n & head_valid;
  assign ins_data  = ins_valid ? buf_data[rd_ptr] : '0;
  assign ins_pc    = ins_valid ? buf_pc[rd_ptr]   : '0;
  assign state_dbg = state;

  // Control: FSM, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= BOOT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= ISSUE;
        end
        ISSUE: begin
          if (jump) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
          end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
              count <= count + CNT_W'(1);
            end else if (pop && !push) begin
              count <= count - CNT_W'(1);
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Storage needs no reset because it is read only behind a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= pc_val;
      buf_data[wr_ptr] <= imem_rdata;
    end
  end

endmodule
